// File: rtl/regfile_pkg.sv
// Shared defaults and state type for the scoreboarded register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_N_RD   = 2;

  // CLEAR: sweeping zeros into the array; READY: accepting reads/writes/reserves.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register 1..DEPTH-1, set by reserve, cleared by write.
// Latency: update visible one edge after request; busy lookup is combinational.
// Backpressure: none; rd_busy tells the issuer to stall, the block itself never stalls.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_RD   = DEF_N_RD
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   w_en,
  input  logic [ADDR_W-1:0]      w_number,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_number,
  input  logic [N_RD*ADDR_W-1:0] r_number,
  output logic [N_RD-1:0]        rd_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;

  // Next pending vector: write clears first, reserve sets after so a new producer wins.
  always_comb begin
    pending_d = pending_q;
    if (w_en && (w_number != '0)) begin
      pending_d[w_number] = 1'b0;
    end
    if (rsv_en && (rsv_number != '0)) begin
      pending_d[rsv_number] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Pending bits register; clr wipes all outstanding reservations.
  always_ff @(posedge clk) begin
    if (clr) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Busy lookup per read port; a same-cycle write to that register is forwarded, so not busy.
  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < N_RD; i++) begin
      rd_busy[i] = (r_number[i*ADDR_W +: ADDR_W] != '0)
                && pending_q[r_number[i*ADDR_W +: ADDR_W]]
                && !(w_en && (w_number == r_number[i*ADDR_W +: ADDR_W]));
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with WB forwarding, pending-write scoreboard and zeroing sweep after clr.
// Latency: reads combinational (forwarded same cycle); writes/reserves take effect at next edge.
// Backpressure: ready low during the DEPTH-1 cycle sweep; traffic offered then is dropped.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_RD   = DEF_N_RD
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [N_RD*ADDR_W-1:0] r_number,
  output logic [N_RD*DATA_W-1:0] data_out,
  output logic [N_RD-1:0]        rd_busy,
  input  logic                   w_en,
  input  logic [ADDR_W-1:0]      w_number,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_number,
  output logic                   ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              ready_q, ready_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;

  logic              w_act;
  logic              rsv_act;
  logic [N_RD-1:0]   sb_busy;

  // Traffic is only honoured in READY and not in the cycle clr is being applied.
  always_comb begin
    w_act   = w_en   && ready_q && !clr && (w_number   != '0);
    rsv_act = rsv_en && ready_q && !clr && (rsv_number != '0);
  end

  // FSM next state, sweep index and the single array write port (sweep or WB write).
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ready_d   = ready_q;
    arr_we    = 1'b0;
    arr_waddr = w_number;
    arr_wdata = data_in;
    case (state_q)
      CLEAR: begin
        arr_we    = !clr;
        arr_waddr = idx_q;
        arr_wdata = '0;
        if (idx_q == LAST_IDX) begin
          state_d = READY;
          ready_d = 1'b1;
          idx_d   = ONE_IDX;
        end else begin
          idx_d = idx_q + ONE_IDX;
        end
      end
      READY: begin
        arr_we = w_act;
      end
    endcase
  end

  // FSM and sweep registers; clr forces CLEAR with the index parked at 1.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= CLEAR;
      idx_q   <= ONE_IDX;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  // Register array; contents are defined only by the sweep and WB writes, never flash-cleared.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      mem_q[arr_waddr] <= arr_wdata;
    end
  end

  // Combinational read ports with WB forwarding; zero while sweeping or for register 0.
  always_comb begin
    data_out = '0;
    for (int i = 0; i < N_RD; i++) begin
      if (ready_q && (r_number[i*ADDR_W +: ADDR_W] != '0)) begin
        if (w_act && (w_number == r_number[i*ADDR_W +: ADDR_W])) begin
          data_out[i*DATA_W +: DATA_W] = data_in;
        end else begin
          data_out[i*DATA_W +: DATA_W] = mem_q[r_number[i*ADDR_W +: ADDR_W]];
        end
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .N_RD   (N_RD)
  ) u_scoreboard (
    .clk        (clk),
    .clr        (clr),
    .w_en       (w_act),
    .w_number   (w_number),
    .rsv_en     (rsv_act),
    .rsv_number (rsv_number),
    .r_number   (r_number),
    .rd_busy    (sb_busy)
  );

  // Busy is suppressed while the sweep runs.
  always_comb begin
    rd_busy = sb_busy & {N_RD{ready_q}};
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus random traffic against a behavioural model.
// Latency: model predicts combinational reads and next-edge updates.
// Backpressure: model treats everything offered while not ready as dropped.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic           clk = 1'b0;
  logic           clr;
  logic [NR*AW-1:0] r_number;
  logic [NR*DW-1:0] data_out;
  logic [NR-1:0]  rd_busy;
  logic           w_en;
  logic [AW-1:0]  w_number;
  logic [DW-1:0]  data_in;
  logic           rsv_en;
  logic [AW-1:0]  rsv_number;
  logic           ready;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: architectural register values, pending set, readiness.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_pend [DEPTH];
  bit            m_rdy = 1'b0;
  int            m_cnt = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR)) dut (
    .clk        (clk),
    .clr        (clr),
    .r_number   (r_number),
    .data_out   (data_out),
    .rd_busy    (rd_busy),
    .w_en       (w_en),
    .w_number   (w_number),
    .data_in    (data_in),
    .rsv_en     (rsv_en),
    .rsv_number (rsv_number),
    .ready      (ready)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] raddr(input int p);
    return r_number[p*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] exp_dat(input int p);
    logic [AW-1:0] a;
    a = raddr(p);
    if (!m_rdy || a == 0) return '0;
    if (w_en && !clr && w_number == a) return data_in;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int p);
    logic [AW-1:0] a;
    a = raddr(p);
    if (!m_rdy || a == 0) return 1'b0;
    if (w_en && !clr && w_number == a) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic logic [DW-1:0] dout(input int p);
    return data_out[p*DW +: DW];
  endfunction

  // Model update at a clock edge: after clr, 31 quiet cycles then every register reads zero.
  task automatic model_edge();
    if (clr) begin
      m_rdy = 1'b0;
      m_cnt = 0;
      for (int k = 0; k < DEPTH; k++) m_pend[k] = 1'b0;
    end else if (!m_rdy) begin
      m_cnt++;
      if (m_cnt == DEPTH - 1) begin
        m_rdy = 1'b1;
        for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
      end
    end else begin
      if (w_en && w_number != 0) begin
        m_mem[w_number] = data_in;
        m_pend[w_number] = 1'b0;
      end
      if (rsv_en && rsv_number != 0) m_pend[rsv_number] = 1'b1;
    end
  endtask

  // Compare every output against the model mid-cycle.
  task automatic sample();
    @(negedge clk);
    chk("ready", {31'b0, ready}, {31'b0, m_rdy});
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("data_out[%0d] a=%0d", p, raddr(p)), dout(p), exp_dat(p));
      chk($sformatf("rd_busy[%0d] a=%0d", p, raddr(p)), {31'b0, rd_busy[p]}, {31'b0, exp_busy(p)});
    end
  endtask

  task automatic commit();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step();
    sample();
    commit();
  endtask

  task automatic idle();
    w_en = 0; w_number = 0; data_in = 0;
    rsv_en = 0; rsv_number = 0; clr = 0;
  endtask

  task automatic setr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    r_number = {a1, a0};
  endtask

  initial begin
    idle();
    setr(0, 0);
    for (int k = 0; k < DEPTH; k++) begin
      m_mem[k] = '0;
      m_pend[k] = 1'b0;
    end

    // Reset: two clr cycles, then the sweep.
    clr = 1;
    @(posedge clk); model_edge(); #1;
    sample();
    chk("rst ready", {31'b0, ready}, 32'd0);
    chk("rst busy", {30'b0, rd_busy}, 32'd0);
    chk("rst dout", data_out[31:0] | data_out[63:32], 32'd0);
    commit();
    clr = 0;
    setr(5, 31);
    for (int c = 1; c <= 31; c++) begin
      sample();
      chk($sformatf("sweep ready low c%0d", c), {31'b0, ready}, 32'd0);
      commit();
    end
    sample();
    chk("ready c32", {31'b0, ready}, 32'd1);
    commit();
    for (int a = 0; a < DEPTH; a += 2) begin
      setr(AW'(a), AW'(a + 1));
      sample();
      chk($sformatf("zeroed r%0d", a), dout(0), 32'd0);
      chk($sformatf("zeroed r%0d", a + 1), dout(1), 32'd0);
      commit();
    end

    // Write with same-cycle forwarding, then registered value.
    w_en = 1; w_number = 5; data_in = 32'hDEADBEEF; setr(5, 0);
    sample(); chk("fwd r5", dout(0), 32'hDEADBEEF); commit();
    idle();
    sample(); chk("stored r5", dout(0), 32'hDEADBEEF); commit();

    // Register zero ignores writes and reserves.
    w_en = 1; w_number = 0; data_in = 32'h1234; rsv_en = 1; rsv_number = 0; setr(0, 0);
    sample();
    chk("r0 p0", dout(0), 32'd0); chk("r0 p1", dout(1), 32'd0);
    commit();
    idle();
    sample(); chk("r0 busy", {30'b0, rd_busy}, 32'd0); chk("r0 after", dout(1), 32'd0); commit();

    // Scoreboard reserve then write.
    rsv_en = 1; rsv_number = 7; setr(7, 5);
    step();
    idle();
    sample(); chk("r7 busy", {31'b0, rd_busy[0]}, 32'd1); commit();
    w_en = 1; w_number = 7; data_in = 32'h55;
    sample();
    chk("r7 busy on wb", {31'b0, rd_busy[0]}, 32'd0);
    chk("r7 fwd", dout(0), 32'h55);
    commit();
    idle();
    sample(); chk("r7 free", {31'b0, rd_busy[0]}, 32'd0); chk("r7 val", dout(0), 32'h55); commit();

    // Reserve and write of the same register in one cycle: reservation survives.
    rsv_en = 1; rsv_number = 9; w_en = 1; w_number = 9; data_in = 32'hAA; setr(5, 9);
    step();
    idle();
    sample(); chk("r9 busy", {31'b0, rd_busy[1]}, 32'd1); chk("r9 val", dout(1), 32'hAA); commit();

    // Reserve of an already pending register; one write frees it.
    rsv_en = 1; rsv_number = 9; step();
    idle(); w_en = 1; w_number = 9; data_in = 32'hBB; step();
    idle(); sample(); chk("r9 freed", {31'b0, rd_busy[1]}, 32'd0); commit();

    // Mid-sweep reset at index 10, with traffic offered during CLEAR.
    clr = 1; step();
    clr = 0;
    for (int c = 1; c <= 9; c++) step();
    clr = 1; w_en = 1; w_number = 3; data_in = 32'h123; step();
    clr = 0; rsv_en = 1; rsv_number = 4; setr(3, 4);
    for (int c = 1; c <= 31; c++) begin
      data_in = $urandom;
      sample();
      chk($sformatf("restart ready low c%0d", c), {31'b0, ready}, 32'd0);
      commit();
    end
    idle();
    sample();
    chk("restart ready", {31'b0, ready}, 32'd1);
    chk("r3 unwritten", dout(0), 32'd0);
    chk("r4 not reserved", {31'b0, rd_busy[1]}, 32'd0);
    commit();
    setr(5, 9);
    sample(); chk("r5 reswept", dout(0), 32'd0); chk("r9 reswept", dout(1), 32'd0); commit();

    // Random traffic on a narrow address range to provoke collisions, rare clr.
    for (int c = 0; c < 600; c++) begin
      w_en       = $urandom_range(0, 1) == 1;
      w_number   = AW'($urandom_range(0, 7));
      data_in    = $urandom;
      rsv_en     = $urandom_range(0, 2) == 0;
      rsv_number = AW'($urandom_range(0, 7));
      setr(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      clr        = $urandom_range(0, 149) == 0;
      step();
    end
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
